seq_divider: RTL and testbench

Multi-cycle integer divider for the 8-bit single-cycle processor's datapath. It performs the inverse of the ALU's combinational multiply and produces a quotient and remainder from two register-file operands over several clock cycles. It uses a START/BUSY/DONE handshake so the control unit can stall the PC while a divide instruction is in flight. Signed and unsigned division are both supported. Results hold stable until the next accepted START.

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider.sv | 132 +++++++++++++
 tb/tb_seq_divider.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared encodings and constants for the sequential divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StDivide = 2'b01,
    StFinish = 2'b10
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Sliced down to WIDTH by the user; supports widths up to 32.
  localparam logic [31:0] DivZeroQuot = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quot_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;

  always_comb begin
    shifted    = {rem_i, dividend_bit_i};
    // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
    trial      = shifted[WIDTH-1:0] - divisor_i;
    quot_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o      = quot_bit_o ? trial : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with START/BUSY/DONE handshake.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_ZERO,
  output logic             ZERO
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] dividend_q;  // magnitude shifts out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] quot_mag;
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i          (rem_q),
    .dividend_bit_i (dividend_q[WIDTH-1]),
    .divisor_i      (divisor_q),
    .rem_o          (step_rem),
    .quot_bit_o     (step_bit)
  );

  always_comb begin
    a_neg    = SIGNED & DATA1[WIDTH-1];
    b_neg    = SIGNED & DATA2[WIDTH-1];
    a_mag    = a_neg ? -DATA1 : DATA1;
    b_mag    = b_neg ? -DATA2 : DATA2;
    quot_mag = {dividend_q[WIDTH-2:0], step_bit};
    quot_fin = neg_quot_q ? -quot_mag : quot_mag;
    rem_fin  = neg_rem_q ? -step_rem : step_rem;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= StIdle;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      quot_q      <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StFinish: begin
          if (!START) begin
            state_q <= StIdle;
          end else if (DATA2 == '0) begin
            state_q     <= StFinish;
            done_q      <= 1'b1;
            quot_q      <= DivZeroQuot[WIDTH-1:0];
            remainder_q <= DATA1;
            div_zero_q  <= 1'b1;
          end else begin
            state_q    <= StDivide;
            busy_q     <= 1'b1;
            dividend_q <= a_mag;
            divisor_q  <= b_mag;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
          end
        end
        StDivide: begin
          rem_q      <= step_rem;
          dividend_q <= quot_mag;
          cnt_q      <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q     <= StFinish;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quot_q      <= quot_fin;
            remainder_q <= rem_fin;
            div_zero_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign QUOTIENT  = quot_q;
  assign REMAINDER = remainder_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DIV_ZERO  = div_zero_q;
  assign ZERO      = (quot_q == '0);

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic       SIGNED = 1'b0;
  logic [7:0] DATA1 = '0;
  logic [7:0] DATA2 = '0;
  logic [7:0] QUOTIENT;
  logic [7:0] REMAINDER;
  logic       BUSY;
  logic       DONE;
  logic       DIV_ZERO;
  logic       ZERO;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seq_divider #(
    .WIDTH(8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .SIGNED    (SIGNED),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DIV_ZERO  (DIV_ZERO),
    .ZERO      (ZERO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (truncating toward zero, remainder follows dividend).
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [7:0] q, output logic [7:0] r, output logic dz);
    int sa;
    int sb;
    if (b == 8'd0) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end
  endtask

  // Issue one divide from a negedge, wait for DONE, and check timing and results.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input bit toggle_start);
    logic [7:0] eq, er;
    logic       edz;
    logic [7:0] prev_q;
    int lat;
    int busy_cnt;
    bit moved;
    model(a, b, s, eq, er, edz);
    prev_q = QUOTIENT;
    START  = 1'b1;
    DATA1  = a;
    DATA2  = b;
    SIGNED = s;
    @(negedge CLK);
    START    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    moved    = 1'b0;
    while (!DONE && lat < 20) begin
      if (BUSY) busy_cnt++;
      if (QUOTIENT !== prev_q) moved = 1'b1;
      if (toggle_start && lat < 5) begin
        START  = ~START;
        DATA1  = 8'd1;
        DATA2  = 8'd1;
        SIGNED = ~SIGNED;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    chk($sformatf("%s latency", tag), 32'(lat), (b == 8'd0) ? 32'd0 : 32'd8);
    chk($sformatf("%s busy_cycles", tag), 32'(busy_cnt), (b == 8'd0) ? 32'd0 : 32'd8);
    chk($sformatf("%s stable_during_divide", tag), 32'(moved), 32'd0);
    chk($sformatf("%s quotient", tag), 32'(QUOTIENT), 32'(eq));
    chk($sformatf("%s remainder", tag), 32'(REMAINDER), 32'(er));
    chk($sformatf("%s div_zero", tag), 32'(DIV_ZERO), 32'(edz));
    chk($sformatf("%s zero", tag), 32'(ZERO), 32'(eq == 8'd0));
    chk($sformatf("%s busy_at_done", tag), 32'(BUSY), 32'd0);
    @(negedge CLK);
    chk($sformatf("%s done_one_cycle", tag), 32'(DONE), 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int w;
    int seen_done;
    logic [7:0] ra, rb;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst quotient", 32'(QUOTIENT), 32'd0);
    chk("rst remainder", 32'(REMAINDER), 32'd0);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst done", 32'(DONE), 32'd0);
    chk("rst div_zero", 32'(DIV_ZERO), 32'd0);
    chk("rst zero", 32'(ZERO), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);

    // Directed cases
    run_div("u200_7", 8'd200, 8'd7, 1'b0, 1'b0);
    run_div("s-7_2", 8'hF9, 8'h02, 1'b1, 1'b0);
    chk("s-7_2 q_literal", 32'(QUOTIENT), 32'hFD);
    chk("s-7_2 r_literal", 32'(REMAINDER), 32'hFF);
    run_div("s7_-2", 8'h07, 8'hFE, 1'b1, 1'b0);
    chk("s7_-2 r_literal", 32'(REMAINDER), 32'h01);
    run_div("u5_0", 8'd5, 8'd0, 1'b0, 1'b0);
    run_div("after_dz", 8'd9, 8'd3, 1'b0, 1'b0);
    run_div("s_ovf", 8'h80, 8'hFF, 1'b1, 1'b0);
    chk("s_ovf q_literal", 32'(QUOTIENT), 32'h80);
    run_div("u3_10", 8'd3, 8'd10, 1'b0, 1'b0);
    run_div("toggle50_5", 8'd50, 8'd5, 1'b0, 1'b1);
    run_div("u255_1", 8'd255, 8'd1, 1'b0, 1'b0);
    run_div("s-128_1", 8'h80, 8'h01, 1'b1, 1'b0);

    // Back-to-back: START held high through FINISH
    START  = 1'b1;
    SIGNED = 1'b0;
    DATA1  = 8'd9;
    DATA2  = 8'd2;
    @(negedge CLK);
    DATA1 = 8'd100;
    DATA2 = 8'd10;
    w = 0;
    while (!DONE && w < 20) begin
      @(negedge CLK);
      w++;
    end
    t1 = cyc;
    chk("b2b first q", 32'(QUOTIENT), 32'd4);
    chk("b2b first r", 32'(REMAINDER), 32'd1);
    @(negedge CLK);
    START = 1'b0;
    chk("b2b no_idle_gap busy", 32'(BUSY), 32'd1);
    w = 0;
    while (!DONE && w < 20) begin
      @(negedge CLK);
      w++;
    end
    t2 = cyc;
    chk("b2b done_spacing", 32'(t2 - t1), 32'd9);
    chk("b2b second q", 32'(QUOTIENT), 32'd10);
    chk("b2b second r", 32'(REMAINDER), 32'd0);
    @(negedge CLK);

    // Reset in the 4th DIVIDE cycle
    START = 1'b1;
    DATA1 = 8'd250;
    DATA2 = 8'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    chk("midrst quotient", 32'(QUOTIENT), 32'd0);
    chk("midrst remainder", 32'(REMAINDER), 32'd0);
    chk("midrst busy", 32'(BUSY), 32'd0);
    chk("midrst done", 32'(DONE), 32'd0);
    chk("midrst div_zero", 32'(DIV_ZERO), 32'd0);
    chk("midrst zero", 32'(ZERO), 32'd1);
    chk("midrst state", 32'(dut.state_q), 32'd0);
    seen_done = 0;
    repeat (12) begin
      @(negedge CLK);
      if (DONE || BUSY) seen_done++;
    end
    chk("midrst no_done", 32'(seen_done), 32'd0);
    run_div("post_rst250_3", 8'd250, 8'd3, 1'b0, 1'b0);
    chk("post_rst q_literal", 32'(QUOTIENT), 32'd83);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_div($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
